// File: rtl/blob_bbox_tracker.sv
// blob_bbox_tracker
//   Classifies each cleaned pixel from the morphology stage as foreground
//   (dark) or background, and accumulates a per-frame foreground count and
//   bounding box. The video stream passes through with one cycle of latency.
//   The previous frame's box outline is drawn over it when that box was valid.
//
// Ports
//   iCLK, iRST       pixel clock; asynchronous active-high reset
//   iFVAL            frame valid, high for the whole active frame
//   iDVAL, iDATA     pixel qualifier and 10-bit pixel
//   oDVAL, oDATA     pass-through stream with the box overlay, 1-cycle latency
//   oX_MIN..oY_MAX   bounding box of the last completed frame
//   oPIX_CNT         foreground count of the last completed frame
//   oBOX_VALID       oPIX_CNT >= MIN_PIXELS for the last completed frame
//   oFRAME_DONE      one-cycle pulse, coincident with the result update
module blob_bbox_tracker #(
  parameter int unsigned IMG_WIDTH  = 800,
  parameter int unsigned IMG_HEIGHT = 600,
  parameter logic [9:0]  THRESH     = 10'h200,
  parameter int unsigned MIN_PIXELS = 16,
  parameter logic [9:0]  BOX_COLOR  = 10'h000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [9:0]  iDATA,
  output logic        oDVAL,
  output logic [9:0]  oDATA,
  output logic [11:0] oX_MIN,
  output logic [11:0] oX_MAX,
  output logic [11:0] oY_MIN,
  output logic [11:0] oY_MAX,
  output logic [19:0] oPIX_CNT,
  output logic        oBOX_VALID,
  output logic        oFRAME_DONE
);

  localparam int unsigned XYW = 12;
  localparam int unsigned CNTW = 20;
  localparam logic [XYW-1:0]  X_LAST  = XYW'(IMG_WIDTH - 1);
  localparam logic [XYW-1:0]  Y_LAST  = XYW'(IMG_HEIGHT - 1);
  localparam logic [CNTW-1:0] MIN_CNT = CNTW'(MIN_PIXELS);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [9:0]      BG      = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             fval_d;
  logic [XYW-1:0]   x, y;
  logic [CNTW-1:0]  cnt;
  logic [XYW-1:0]   xmin, xmax, ymin, ymax;

  logic fval_rise, fval_fall, fg, in_box, on_edge, outline;

  assign fval_rise = iFVAL & ~fval_d;
  assign fval_fall = ~iFVAL & fval_d;
  assign fg        = (iDATA < THRESH);

  // Overlay test against the previously published box
  assign in_box  = (x >= oX_MIN) && (x <= oX_MAX) && (y >= oY_MIN) && (y <= oY_MAX);
  assign on_edge = (x == oX_MIN) || (x == oX_MAX) || (y == oY_MIN) || (y == oY_MAX);
  assign outline = (state == ACTIVE) && oBOX_VALID && in_box && on_edge;

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fval_rise) state_nxt = ACTIVE;
      ACTIVE:  if (fval_fall) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame edge tracking; resets high so a frame in flight at reset is skipped
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) fval_d <= 1'b1;
    else      fval_d <= iFVAL;
  end

  // Position counters and per-frame accumulators
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x    <= '0;
      y    <= '0;
      cnt  <= '0;
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
    end else if (state == IDLE && state_nxt == ACTIVE) begin
      x    <= '0;
      y    <= '0;
      cnt  <= '0;
      xmin <= {XYW{1'b1}};
      xmax <= '0;
      ymin <= {XYW{1'b1}};
      ymax <= '0;
    end else if (state == ACTIVE && iDVAL) begin
      if (fg) begin
        if (cnt != CNT_MAX) cnt <= cnt + CNTW'(1);
        if (x < xmin) xmin <= x;
        if (x > xmax) xmax <= x;
        if (y < ymin) ymin <= y;
        if (y > ymax) ymax <= y;
      end
      // X is positional; extra lines fold onto the last row
      if (x == X_LAST) begin
        x <= '0;
        if (y != Y_LAST) y <= y + XYW'(1);
      end else begin
        x <= x + XYW'(1);
      end
    end
  end

  // Result publication on the DONE cycle
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oPIX_CNT    <= '0;
      oX_MIN      <= '0;
      oX_MAX      <= '0;
      oY_MIN      <= '0;
      oY_MAX      <= '0;
      oBOX_VALID  <= 1'b0;
      oFRAME_DONE <= 1'b0;
    end else begin
      oFRAME_DONE <= (state == DONE);
      if (state == DONE) begin
        oPIX_CNT   <= cnt;
        oBOX_VALID <= (cnt >= MIN_CNT);
        if (cnt != '0) begin
          oX_MIN <= xmin;
          oX_MAX <= xmax;
          oY_MIN <= ymin;
          oY_MAX <= ymax;
        end else begin
          oX_MIN <= '0;
          oX_MAX <= '0;
          oY_MIN <= '0;
          oY_MAX <= '0;
        end
      end
    end
  end

  // Video pass-through with the outline overlay
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oDATA <= BG;
    end else begin
      oDVAL <= iDVAL;
      if (!iDVAL)      oDATA <= BG;
      else if (outline) oDATA <= BOX_COLOR;
      else             oDATA <= iDATA;
    end
  end

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Directed bench for blob_bbox_tracker on a tiny 8x6 image.
module tb_blob_bbox_tracker;

  localparam int W = 8;
  localparam int H = 6;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iFVAL;
  logic        iDVAL;
  logic [9:0]  iDATA;
  logic        oDVAL;
  logic [9:0]  oDATA;
  logic [11:0] oX_MIN, oX_MAX, oY_MIN, oY_MAX;
  logic [19:0] oPIX_CNT;
  logic        oBOX_VALID;
  logic        oFRAME_DONE;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int box_hits = 0;

  logic [9:0] img [0:7][0:7];
  bit ov_valid;
  int ov_xmin, ov_xmax, ov_ymin, ov_ymax;

  blob_bbox_tracker #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .MIN_PIXELS(4)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iFVAL      (iFVAL),
    .iDVAL      (iDVAL),
    .iDATA      (iDATA),
    .oDVAL      (oDVAL),
    .oDATA      (oDATA),
    .oX_MIN     (oX_MIN),
    .oX_MAX     (oX_MAX),
    .oY_MIN     (oY_MIN),
    .oY_MAX     (oY_MAX),
    .oPIX_CNT   (oPIX_CNT),
    .oBOX_VALID (oBOX_VALID),
    .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] expect_pix(input int x, input int y, input logic [9:0] d);
    if (ov_valid && x >= ov_xmin && x <= ov_xmax && y >= ov_ymin && y <= ov_ymax &&
        (x == ov_xmin || x == ov_xmax || y == ov_ymin || y == ov_ymax))
      return 10'h000;
    return d;
  endfunction

  // One clock: apply inputs, sample 1 time unit after the edge
  task automatic cycle(input logic fval, input logic dval, input logic [9:0] data,
                       input bit chk, input logic [9:0] exp_data);
    iFVAL = fval;
    iDVAL = dval;
    iDATA = data;
    @(posedge iCLK);
    #1;
    if (oFRAME_DONE) pulses++;
    if (oDVAL && oDATA == 10'h000) box_hits++;
    if (chk) begin
      check("odval", 32'(oDVAL), 32'(dval));
      check("odata", 32'(oDATA), 32'(exp_data));
    end
  endtask

  task automatic fill_bg();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = 10'h3FF;
  endtask

  task automatic send_frame(input int nlines, input bit gaps);
    pulses = 0;
    box_hits = 0;
    cycle(1'b1, 1'b0, 10'h000, 1'b1, 10'h3FF);
    for (int r = 0; r < nlines; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps && (c == 3 || c == 6))
          cycle(1'b1, 1'b0, 10'h155, 1'b1, 10'h3FF);
        cycle(1'b1, 1'b1, img[r][c], 1'b1,
              expect_pix(c, (r > H - 1) ? H - 1 : r, img[r][c]));
      end
      cycle(1'b1, 1'b0, 10'h000, 1'b1, 10'h3FF);
    end
    cycle(1'b1, 1'b0, 10'h000, 1'b1, 10'h3FF);
    repeat (3) cycle(1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF);
  endtask

  task automatic check_results(input string tag, input int cnt, input int xmn, input int xmx,
                               input int ymn, input int ymx, input int vld);
    check({tag, "_cnt"},   32'(oPIX_CNT),   32'(cnt));
    check({tag, "_xmin"},  32'(oX_MIN),     32'(xmn));
    check({tag, "_xmax"},  32'(oX_MAX),     32'(xmx));
    check({tag, "_ymin"},  32'(oY_MIN),     32'(ymn));
    check({tag, "_ymax"},  32'(oY_MAX),     32'(ymx));
    check({tag, "_valid"}, 32'(oBOX_VALID), 32'(vld));
  endtask

  initial begin
    iRST = 1'b1;
    iFVAL = 1'b0;
    iDVAL = 1'b0;
    iDATA = 10'h000;
    ov_valid = 1'b0;
    ov_xmin = 0; ov_xmax = 0; ov_ymin = 0; ov_ymax = 0;

    @(posedge iCLK);
    #1;
    check_results("reset", 0, 0, 0, 0, 0, 0);
    check("reset_odata", 32'(oDATA), 32'h3FF);
    check("reset_odval", 32'(oDVAL), 32'd0);
    check("reset_done",  32'(oFRAME_DONE), 32'd0);
    iRST = 1'b0;
    repeat (2) cycle(1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF);

    // Three isolated dark pixels, below MIN_PIXELS
    fill_bg();
    img[0][0] = 10'h000;
    img[5][7] = 10'h000;
    img[3][3] = 10'h000;
    send_frame(H, 1'b0);
    check("three_pulses", 32'(pulses), 32'd1);
    check_results("three", 3, 0, 7, 0, 5, 0);

    // Reset in the middle of a frame
    cycle(1'b1, 1'b0, 10'h000, 1'b1, 10'h3FF);
    repeat (3) cycle(1'b1, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
    iRST = 1'b1;
    #1;
    check_results("midrst", 0, 0, 0, 0, 0, 0);
    check("midrst_odata", 32'(oDATA), 32'h3FF);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    pulses = 0;
    repeat (5) cycle(1'b1, 1'b1, 10'h000, 1'b1, 10'h000);
    repeat (3) cycle(1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF);
    check("midrst_pulses", 32'(pulses), 32'd0);
    check("midrst_cnt", 32'(oPIX_CNT), 32'd0);

    // 3x2 dark blob at x=2..4, y=1..2
    fill_bg();
    for (int r = 1; r <= 2; r++)
      for (int c = 2; c <= 4; c++)
        img[r][c] = 10'h000;
    send_frame(H, 1'b0);
    check("blob_pulses", 32'(pulses), 32'd1);
    check_results("blob", 6, 2, 4, 1, 2, 1);

    // Background frame with gaps: overlay shows the blob box
    ov_valid = 1'b1;
    ov_xmin = 2; ov_xmax = 4; ov_ymin = 1; ov_ymax = 2;
    fill_bg();
    send_frame(H, 1'b1);
    check("ovl_pulses", 32'(pulses), 32'd1);
    check("ovl_hits", 32'(box_hits), 32'd6);
    check_results("empty", 0, 0, 0, 0, 0, 0);

    // Following frame: empty result means no overlay
    ov_valid = 1'b0;
    send_frame(H, 1'b0);
    check("noovl_hits", 32'(box_hits), 32'd0);
    check_results("empty2", 0, 0, 0, 0, 0, 0);

    // Overrun: 8 lines, dark pixel on the 8th line folds onto row 5
    fill_bg();
    img[7][1] = 10'h000;
    send_frame(8, 1'b0);
    check("ovr_pulses", 32'(pulses), 32'd1);
    check_results("ovr", 1, 1, 1, 5, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
